// File: rtl/pt2262_pkg.sv
// rtl/pt2262_pkg.sv - shared types, timing constants and waveform helpers for the PT2262 encoder
//
// Purpose:
//   Trit and FSM state enums, the tick-domain timing constants of the PT2262
//   code word, and the pure functions that turn a (trit, tick offset) pair
//   into the serial output level.
// Contents:
//   trit_e       : ZERO / ONE / FLOAT
//   state_e      : IDLE / BIT / SYNC
//   decode_trit  : 2-bit address field -> trit
//   position_trit: word position 0..11 -> trit (A0..A7 then D0..D3)
//   bit_level    : output level of one bit at tick offset 0..31
//   sync_level   : output level of the sync period at tick offset 0..127

package pt2262_pkg;

  typedef enum logic [1:0] {
    ZERO  = 2'd0,
    ONE   = 2'd1,
    FLOAT = 2'd2
  } trit_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BIT  = 2'd1,
    SYNC = 2'd2
  } state_e;

  // All durations are in ticks of the 12 kHz oscillator.
  localparam int BIT_TICKS  = 32;
  localparam int SEG_TICKS  = 16;
  localparam int SHORT_HI   = 4;
  localparam int LONG_HI    = 12;
  localparam int SYNC_TICKS = 128;
  localparam int SYNC_HI    = 4;

  // Word layout: eight address trits followed by four data bits.
  localparam int NUM_ADDR = 8;
  localparam int NUM_POS  = 12;

  // Both 2'b10 and 2'b11 select FLOAT.
  function automatic trit_e decode_trit(logic [1:0] code);
    trit_e t;
    case (code)
      2'b00:   t = ZERO;
      2'b01:   t = ONE;
      default: t = FLOAT;
    endcase
    return t;
  endfunction

  function automatic trit_e position_trit(logic [15:0] addr_w, logic [3:0] data_w,
                                          logic [3:0] idx);
    trit_e t;
    if (int'(idx) < NUM_ADDR) begin
      t = decode_trit(addr_w[{idx[2:0], 1'b0} +: 2]);
    end else begin
      // Positions 8..11 map onto data[0..3] through the low two index bits.
      t = data_w[idx[1:0]] ? ONE : ZERO;
    end
    return t;
  endfunction

  // tick[4] selects the segment (SEG_TICKS = 16), tick[3:0] is the offset
  // inside it. FLOAT is the only trit whose two segments differ.
  function automatic logic bit_level(trit_e t, logic [4:0] tick);
    logic long_seg;
    long_seg = (t == ONE) || ((t == FLOAT) && tick[4]);
    if (long_seg) begin
      return int'(tick[3:0]) < LONG_HI;
    end
    return int'(tick[3:0]) < SHORT_HI;
  endfunction

  function automatic logic sync_level(logic [6:0] tick);
    return int'(tick) < SYNC_HI;
  endfunction

endpackage

// File: rtl/pt2262_encoder.sv
// rtl/pt2262_encoder.sv - PT2262-format serial code word encoder
//
// Purpose:
//   Serialises eight address trits and four data bits into the PT2262 remote
//   control waveform, followed by a sync period. While te is held (and for at
//   least MIN_WORDS words per activation) words repeat back to back, each one
//   re-latching addr/data at its first tick.
// Ports:
//   clk    in   system clock, everything on the rising edge
//   reset  in   synchronous active-high reset
//   osc_12 in   12 kHz oscillator level (clk-synchronous); its rising edge is the tick
//   te     in   transmit enable, sampled only on the tick that starts or ends a word
//   addr   in   [15:0] address trits, trit k in addr[2k+1:2k]
//   data   in   [3:0] data bits, D0 = data[0]
//   dout   out  registered serial waveform
//   busy   out  high while a word (bits or sync) is in progress

module pt2262_encoder
  import pt2262_pkg::*;
#(
  parameter int MIN_WORDS = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        osc_12,
  input  logic        te,
  input  logic [15:0] addr,
  input  logic [3:0]  data,
  output logic        dout,
  output logic        busy
);

  localparam int WCW = (MIN_WORDS < 1) ? 1 : $clog2(MIN_WORDS + 1);

  state_e          state_q, state_d;
  logic            osc_prev_q, osc_prev_d;
  logic [3:0]      bit_idx_q, bit_idx_d;
  logic [6:0]      tick_cnt_q, tick_cnt_d;
  logic [WCW-1:0]  word_cnt_q, word_cnt_d;
  logic [15:0]     addr_q, addr_d;
  logic [3:0]      data_q, data_d;
  logic            dout_q, dout_d;

  logic            tick;
  logic            start_word;
  logic [WCW-1:0]  word_cnt_inc;

  always_comb begin
    osc_prev_d   = osc_12;
    state_d      = state_q;
    bit_idx_d    = bit_idx_q;
    tick_cnt_d   = tick_cnt_q;
    word_cnt_d   = word_cnt_q;
    addr_d       = addr_q;
    data_d       = data_q;
    dout_d       = dout_q;
    start_word   = 1'b0;
    word_cnt_inc = word_cnt_q;

    tick = osc_12 & ~osc_prev_q;

    if (tick) begin
      case (state_q)
        IDLE: begin
          if (te) begin
            start_word = 1'b1;
            word_cnt_d = '0;
          end
        end

        BIT: begin
          if (tick_cnt_q == 7'(BIT_TICKS - 1)) begin
            tick_cnt_d = '0;
            if (bit_idx_q == 4'(NUM_POS - 1)) begin
              state_d = SYNC;
            end else begin
              bit_idx_d = bit_idx_q + 4'd1;
            end
          end else begin
            tick_cnt_d = tick_cnt_q + 7'd1;
          end
        end

        SYNC: begin
          if (tick_cnt_q == 7'(SYNC_TICKS - 1)) begin
            // This tick closes the word and doubles as the first tick of the
            // next one, so repeated words have no gap between them.
            if (word_cnt_q != WCW'(MIN_WORDS)) begin
              word_cnt_inc = word_cnt_q + WCW'(1);
            end
            word_cnt_d = word_cnt_inc;
            if ((int'(word_cnt_inc) >= MIN_WORDS) && !te) begin
              state_d    = IDLE;
              tick_cnt_d = '0;
              bit_idx_d  = '0;
            end else begin
              start_word = 1'b1;
            end
          end else begin
            tick_cnt_d = tick_cnt_q + 7'd1;
          end
        end

        default: begin
          state_d = IDLE;
        end
      endcase

      if (start_word) begin
        state_d    = BIT;
        bit_idx_d  = '0;
        tick_cnt_d = '0;
        addr_d     = addr;
        data_d     = data;
      end

      // Level for the tick period that starts now, taken from the next-state
      // values so the register lands on it at this same edge.
      case (state_d)
        BIT:     dout_d = bit_level(position_trit(addr_d, data_d, bit_idx_d), tick_cnt_d[4:0]);
        SYNC:    dout_d = sync_level(tick_cnt_d);
        default: dout_d = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      // History of 1 means osc_12 already high at release is not a tick.
      osc_prev_q <= 1'b1;
      bit_idx_q  <= '0;
      tick_cnt_q <= '0;
      word_cnt_q <= '0;
      addr_q     <= '0;
      data_q     <= '0;
      dout_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      osc_prev_q <= osc_prev_d;
      bit_idx_q  <= bit_idx_d;
      tick_cnt_q <= tick_cnt_d;
      word_cnt_q <= word_cnt_d;
      addr_q     <= addr_d;
      data_q     <= data_d;
      dout_q     <= dout_d;
    end
  end

  assign dout = dout_q;
  assign busy = (state_q != IDLE);

endmodule
